// File: rtl/gemm_pkg.sv
// gemm_pkg: shared definitions for the GEMM tile sequencer and its helpers.
// Holds the sequencer state encoding, status-word bit positions, default
// tiling parameters and a size-legality helper.
package gemm_pkg;

  localparam int TILE_DEF    = 4;
  localparam int MAX_DIM_DEF = 256;
  localparam int IDX_W_DEF   = 16;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ERR     = 2;
  localparam int STAT_CNT_LSB = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_FETCH_W = 3'd2,
    S_FETCH_I = 3'd3,
    S_COMPUTE = 3'd4,
    S_WAIT    = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  // A dimension is usable when it is non-zero and no larger than max_dim.
  function automatic logic size_legal(input logic [31:0] sz, input logic [31:0] max_dim);
    return (sz != 32'd0) && (sz <= max_dim);
  endfunction

endpackage

// File: rtl/gemm_tile_addr_gen.sv
// tile_addr_gen: combinational tile geometry for a GEMM tile loop.
// Ports:
//   mt, nt, kt          tile indices (M, N, K)
//   m_dim, k_dim, n_dim matrix sizes, already truncated to IDX_W
//   wgt_base, inp_base  byte base addresses of W and A (row-major, 1 B/elem)
//   wgt_addr, inp_addr  start byte address of the W tile (kt,nt) / A tile (mt,kt)
//   m_len, k_len, n_len edge-clipped tile extents, min(TILE, dim - idx*TILE)
//   tm, tk, tn          tile counts ceil(dim / TILE)
module tile_addr_gen
  import gemm_pkg::*;
#(
  parameter int TILE  = TILE_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic [IDX_W-1:0] mt,
  input  logic [IDX_W-1:0] nt,
  input  logic [IDX_W-1:0] kt,
  input  logic [IDX_W-1:0] m_dim,
  input  logic [IDX_W-1:0] k_dim,
  input  logic [IDX_W-1:0] n_dim,
  input  logic [31:0]      wgt_base,
  input  logic [31:0]      inp_base,
  output logic [31:0]      wgt_addr,
  output logic [31:0]      inp_addr,
  output logic [IDX_W-1:0] m_len,
  output logic [IDX_W-1:0] k_len,
  output logic [IDX_W-1:0] n_len,
  output logic [IDX_W-1:0] tm,
  output logic [IDX_W-1:0] tk,
  output logic [IDX_W-1:0] tn
);

  localparam int               SH     = $clog2(TILE);
  localparam logic [IDX_W-1:0] TILE_V = IDX_W'(TILE);

  // Remaining extent of a dimension from tile idx onward, clipped to TILE.
  function automatic logic [IDX_W-1:0] tile_len(input logic [IDX_W-1:0] dim,
                                                input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] rem;
    rem = dim - (idx << SH);
    if (rem > TILE_V) begin
      return TILE_V;
    end else begin
      return rem;
    end
  endfunction

  logic [31:0] mt_w, nt_w, kt_w, k_w, n_w;

  assign mt_w = {{(32-IDX_W){1'b0}}, mt};
  assign nt_w = {{(32-IDX_W){1'b0}}, nt};
  assign kt_w = {{(32-IDX_W){1'b0}}, kt};
  assign k_w  = {{(32-IDX_W){1'b0}}, k_dim};
  assign n_w  = {{(32-IDX_W){1'b0}}, n_dim};

  // Row-major tile origins; all sums wrap modulo 2^32.
  assign wgt_addr = wgt_base + (kt_w << SH) * n_w + (nt_w << SH);
  assign inp_addr = inp_base + (mt_w << SH) * k_w + (kt_w << SH);

  assign m_len = tile_len(m_dim, mt);
  assign k_len = tile_len(k_dim, kt);
  assign n_len = tile_len(n_dim, nt);

  assign tm = (m_dim + TILE_V - IDX_W'(1)) >> SH;
  assign tk = (k_dim + TILE_V - IDX_W'(1)) >> SH;
  assign tn = (n_dim + TILE_V - IDX_W'(1)) >> SH;

endmodule

// File: rtl/gemm_tile_sequencer.sv
// gemm_tile_sequencer: drives the tile loop of C = A * W.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   start                        one-cycle start pulse (honoured in IDLE only)
//   m_size, k_size, n_size       GEMM dimensions
//   wgt_base, inp_base           byte addresses of W[0][0] and A[0][0]
//   req_*                        tile fetch request to the memory reader
//   cmp_*                        compute command / completion with the array
//   status                       [0] busy [1] done [2] error [31:16] tiles done
// All outputs are registered; the next-output values are computed from the
// next state and next loop indices so fields are stable across a stall.
module gemm_tile_sequencer
  import gemm_pkg::*;
#(
  parameter int TILE    = TILE_DEF,
  parameter int MAX_DIM = MAX_DIM_DEF,
  parameter int IDX_W   = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      m_size,
  input  logic [31:0]      k_size,
  input  logic [31:0]      n_size,
  input  logic [31:0]      wgt_base,
  input  logic [31:0]      inp_base,
  output logic             req_valid,
  input  logic             req_ready,
  output logic             req_is_wgt,
  output logic [31:0]      req_addr,
  output logic [31:0]      req_stride,
  output logic [IDX_W-1:0] req_rows,
  output logic [IDX_W-1:0] req_cols,
  output logic             cmp_valid,
  input  logic             cmp_ready,
  output logic             cmp_first,
  output logic             cmp_last,
  input  logic             cmp_done,
  output logic [31:0]      status
);

  state_t           state_r, state_s;
  logic [IDX_W-1:0] mt_r, nt_r, kt_r, mt_s, nt_s, kt_s;
  logic [31:0]      m_r, k_r, n_r, wb_r, ib_r;
  logic [31:0]      m_s, k_s, n_s, wb_s, ib_s;
  logic             busy_r, done_r, err_r, busy_s, done_s, err_s;
  logic [15:0]      cnt_r, cnt_s;

  logic             req_valid_s, req_is_wgt_s, cmp_valid_s, cmp_first_s, cmp_last_s;
  logic [31:0]      req_addr_s, req_stride_s;
  logic [IDX_W-1:0] req_rows_s, req_cols_s;

  logic [31:0]      wgt_addr_s, inp_addr_s;
  logic [IDX_W-1:0] m_len_s, k_len_s, n_len_s, tm_s, tk_s, tn_s;

  // Geometry is evaluated on the next indices so it lands with the next state.
  tile_addr_gen #(.TILE(TILE), .IDX_W(IDX_W)) u_addr (
    .mt       (mt_s),
    .nt       (nt_s),
    .kt       (kt_s),
    .m_dim    (m_r[IDX_W-1:0]),
    .k_dim    (k_r[IDX_W-1:0]),
    .n_dim    (n_r[IDX_W-1:0]),
    .wgt_base (wb_r),
    .inp_base (ib_r),
    .wgt_addr (wgt_addr_s),
    .inp_addr (inp_addr_s),
    .m_len    (m_len_s),
    .k_len    (k_len_s),
    .n_len    (n_len_s),
    .tm       (tm_s),
    .tk       (tk_s),
    .tn       (tn_s)
  );

  // Next-state, loop-index, status and output computation.
  always_comb begin
    state_s = state_r;
    mt_s = mt_r;  nt_s = nt_r;  kt_s = kt_r;
    m_s = m_r;    k_s = k_r;    n_s = n_r;  wb_s = wb_r;  ib_s = ib_r;
    busy_s = busy_r;  done_s = done_r;  err_s = err_r;  cnt_s = cnt_r;

    case (state_r)
      S_IDLE: begin
        if (start) begin
          m_s = m_size;  k_s = k_size;  n_s = n_size;
          wb_s = wgt_base;  ib_s = inp_base;
          busy_s = 1'b1;  done_s = 1'b0;  err_s = 1'b0;  cnt_s = 16'd0;
          state_s = S_CHECK;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CHECK: begin
        if (size_legal(m_r, 32'(MAX_DIM)) && size_legal(k_r, 32'(MAX_DIM)) &&
            size_legal(n_r, 32'(MAX_DIM))) begin
          mt_s = '0;  nt_s = '0;  kt_s = '0;
          state_s = S_FETCH_W;
        end else begin
          err_s = 1'b1;  done_s = 1'b1;  busy_s = 1'b0;
          state_s = S_IDLE;
        end
      end
      S_FETCH_W: begin
        if (req_ready) state_s = S_FETCH_I;
        else           state_s = S_FETCH_W;
      end
      S_FETCH_I: begin
        if (req_ready) state_s = S_COMPUTE;
        else           state_s = S_FETCH_I;
      end
      S_COMPUTE: begin
        if (cmp_ready) state_s = S_WAIT;
        else           state_s = S_COMPUTE;
      end
      S_WAIT: begin
        if (!cmp_done) begin
          state_s = S_WAIT;
        end else if (kt_r != tk_s - IDX_W'(1)) begin
          kt_s = kt_r + IDX_W'(1);
          state_s = S_FETCH_W;
        end else begin
          // Output tile (mt, nt) is finished: nt advances first, then mt.
          cnt_s = cnt_r + 16'd1;
          kt_s = '0;
          if (nt_r != tn_s - IDX_W'(1)) begin
            nt_s = nt_r + IDX_W'(1);
            state_s = S_FETCH_W;
          end else if (mt_r != tm_s - IDX_W'(1)) begin
            nt_s = '0;
            mt_s = mt_r + IDX_W'(1);
            state_s = S_FETCH_W;
          end else begin
            nt_s = '0;
            mt_s = '0;
            state_s = S_DONE;
          end
        end
      end
      S_DONE: begin
        busy_s = 1'b0;  done_s = 1'b1;
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    req_valid_s  = 1'b0;  req_is_wgt_s = 1'b0;
    req_addr_s   = 32'd0; req_stride_s = 32'd0;
    req_rows_s   = '0;    req_cols_s   = '0;
    if (state_s == S_FETCH_W) begin
      req_valid_s  = 1'b1;  req_is_wgt_s = 1'b1;
      req_addr_s   = wgt_addr_s;
      req_stride_s = {{(32-IDX_W){1'b0}}, n_r[IDX_W-1:0]};
      req_rows_s   = k_len_s;  req_cols_s = n_len_s;
    end else if (state_s == S_FETCH_I) begin
      req_valid_s  = 1'b1;  req_is_wgt_s = 1'b0;
      req_addr_s   = inp_addr_s;
      req_stride_s = {{(32-IDX_W){1'b0}}, k_r[IDX_W-1:0]};
      req_rows_s   = m_len_s;  req_cols_s = k_len_s;
    end else begin
      req_valid_s  = 1'b0;
    end

    cmp_valid_s = 1'b0;  cmp_first_s = 1'b0;  cmp_last_s = 1'b0;
    if (state_s == S_COMPUTE) begin
      cmp_valid_s = 1'b1;
      cmp_first_s = (kt_s == '0);
      cmp_last_s  = (kt_s == tk_s - IDX_W'(1));
    end else begin
      cmp_valid_s = 1'b0;
    end
  end

  // State, index, latched-operand, status and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      mt_r <= '0;  nt_r <= '0;  kt_r <= '0;
      m_r <= 32'd0;  k_r <= 32'd0;  n_r <= 32'd0;  wb_r <= 32'd0;  ib_r <= 32'd0;
      busy_r <= 1'b0;  done_r <= 1'b0;  err_r <= 1'b0;  cnt_r <= 16'd0;
      req_valid <= 1'b0;  req_is_wgt <= 1'b0;  req_addr <= 32'd0;
      req_stride <= 32'd0;  req_rows <= '0;  req_cols <= '0;
      cmp_valid <= 1'b0;  cmp_first <= 1'b0;  cmp_last <= 1'b0;
    end else begin
      state_r <= state_s;
      mt_r <= mt_s;  nt_r <= nt_s;  kt_r <= kt_s;
      m_r <= m_s;  k_r <= k_s;  n_r <= n_s;  wb_r <= wb_s;  ib_r <= ib_s;
      busy_r <= busy_s;  done_r <= done_s;  err_r <= err_s;  cnt_r <= cnt_s;
      req_valid <= req_valid_s;  req_is_wgt <= req_is_wgt_s;  req_addr <= req_addr_s;
      req_stride <= req_stride_s;  req_rows <= req_rows_s;  req_cols <= req_cols_s;
      cmp_valid <= cmp_valid_s;  cmp_first <= cmp_first_s;  cmp_last <= cmp_last_s;
    end
  end

  always_comb begin
    status                          = 32'd0;
    status[STAT_BUSY]               = busy_r;
    status[STAT_DONE]               = done_r;
    status[STAT_ERR]                = err_r;
    status[STAT_CNT_LSB +: 16]      = cnt_r;
  end

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// tb_gemm_tile_sequencer: directed self-checking bench for gemm_tile_sequencer.
// A small array model pulses cmp_done two cycles after each accepted command;
// a negedge monitor logs every request/command handshake for later checking.
module tb_gemm_tile_sequencer;
  import gemm_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, req_ready, cmp_ready, cmp_done;
  logic [31:0] m_size, k_size, n_size, wgt_base, inp_base;
  logic        req_valid, req_is_wgt, cmp_valid, cmp_first, cmp_last;
  logic [31:0] req_addr, req_stride, status;
  logic [15:0] req_rows, req_cols;

  int n_checks = 0;
  int n_fail   = 0;
  int req_n, cmp_n;
  logic        done_en;
  logic [31:0] log_addr [64];
  logic [31:0] log_stride [64];
  logic [15:0] log_rows [64];
  logic [15:0] log_cols [64];
  logic        log_wgt [64];
  logic        log_first [64];
  logic        log_last [64];

  always #5 clk = ~clk;

  gemm_tile_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .m_size(m_size), .k_size(k_size), .n_size(n_size),
    .wgt_base(wgt_base), .inp_base(inp_base),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_wgt(req_is_wgt),
    .req_addr(req_addr), .req_stride(req_stride),
    .req_rows(req_rows), .req_cols(req_cols),
    .cmp_valid(cmp_valid), .cmp_ready(cmp_ready),
    .cmp_first(cmp_first), .cmp_last(cmp_last), .cmp_done(cmp_done),
    .status(status)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Handshake logger, sampled mid-cycle.
  always @(negedge clk) begin
    if (req_valid && req_ready) begin
      if (req_n < 64) begin
        log_addr[req_n] = req_addr;  log_stride[req_n] = req_stride;
        log_rows[req_n] = req_rows;  log_cols[req_n]   = req_cols;
        log_wgt[req_n]  = req_is_wgt;
      end
      req_n++;
    end
    if (cmp_valid && cmp_ready) begin
      if (cmp_n < 64) begin
        log_first[cmp_n] = cmp_first;  log_last[cmp_n] = cmp_last;
      end
      cmp_n++;
    end
  end

  // Array model: completion pulse two cycles after each accepted command.
  initial begin
    cmp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (cmp_valid && cmp_ready && done_en) begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        cmp_done = 1'b1;
        @(posedge clk); #1;
        cmp_done = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    req_n = 0;
    cmp_n = 0;
  endtask

  task automatic pulse_start(input logic [31:0] m, input logic [31:0] k, input logic [31:0] n);
    tick();
    m_size = m;  k_size = k;  n_size = n;
    wgt_base = 32'h0000_1000;  inp_base = 32'h0000_2000;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 4000; i++) begin
      if (status[STAT_DONE]) break;
      tick();
    end
    check_val({tag, "_finished"}, 32'(status[STAT_DONE]), 32'd1);
  endtask

  initial begin
    rst = 1'b1;  start = 1'b0;  req_ready = 1'b1;  cmp_ready = 1'b1;  done_en = 1'b1;
    m_size = 32'd0;  k_size = 32'd0;  n_size = 32'd0;
    wgt_base = 32'd0;  inp_base = 32'd0;
    clear_logs();
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check_val("rst_status", status, 32'd0);
    check_val("rst_valids", {30'd0, req_valid, cmp_valid}, 32'd0);
    check_val("rst_addr", req_addr, 32'd0);

    // 8x8x8: Tm=Tk=Tn=2
    clear_logs();
    pulse_start(32'd8, 32'd8, 32'd8);
    check_val("busy_after_start", status, 32'h0000_0001);
    wait_done("r888");
    check_val("r888_status", status, 32'h0004_0002);
    check_val("r888_req_cnt", 32'(req_n), 32'd16);
    check_val("r888_cmp_cnt", 32'(cmp_n), 32'd8);
    check_val("r888_w0_addr", log_addr[0], 32'h0000_1000);
    check_val("r888_w0_stride", log_stride[0], 32'd8);
    check_val("r888_w0_wgt", 32'(log_wgt[0]), 32'd1);
    check_val("r888_a0_addr", log_addr[1], 32'h0000_2000);
    check_val("r888_a0_stride", log_stride[1], 32'd8);
    check_val("r888_a0_wgt", 32'(log_wgt[1]), 32'd0);
    check_val("r888_w1_addr", log_addr[2], 32'h0000_1020);
    check_val("r888_a1_addr", log_addr[3], 32'h0000_2004);
    check_val("r888_w_nt1", log_addr[4], 32'h0000_1004);
    check_val("r888_a_mt1", log_addr[9], 32'h0000_2020);
    check_val("r888_c0_flags", {30'd0, log_first[0], log_last[0]}, 32'd2);
    check_val("r888_c1_flags", {30'd0, log_first[1], log_last[1]}, 32'd1);

    // 5x6x3 edge tiles: Tm=2, Tk=2, Tn=1
    clear_logs();
    pulse_start(32'd5, 32'd6, 32'd3);
    wait_done("r563");
    check_val("r563_status", status, 32'h0002_0002);
    check_val("r563_req_cnt", 32'(req_n), 32'd8);
    check_val("r563_cmp_cnt", 32'(cmp_n), 32'd4);
    check_val("r563_w0_rows", 32'(log_rows[0]), 32'd4);
    check_val("r563_w0_cols", 32'(log_cols[0]), 32'd3);
    check_val("r563_w0_stride", log_stride[0], 32'd3);
    check_val("r563_w1_rows", 32'(log_rows[2]), 32'd2);
    check_val("r563_w1_addr", log_addr[2], 32'h0000_100C);
    check_val("r563_a0_stride", log_stride[1], 32'd6);
    check_val("r563_a1_cols", 32'(log_cols[3]), 32'd2);
    check_val("r563_a_mt1_addr", log_addr[5], 32'h0000_2018);
    check_val("r563_a_mt1_rows", 32'(log_rows[5]), 32'd1);

    // Illegal sizes: k=0 then n=300
    clear_logs();
    pulse_start(32'd8, 32'd0, 32'd8);
    check_val("k0_busy", status, 32'h0000_0001);
    tick();
    check_val("k0_status", status, 32'h0000_0006);
    repeat (3) tick();
    check_val("k0_no_req", 32'(req_n), 32'd0);
    pulse_start(32'd8, 32'd8, 32'd300);
    check_val("n300_busy", status, 32'h0000_0001);
    tick();
    check_val("n300_status", status, 32'h0000_0006);
    repeat (3) tick();
    check_val("n300_no_req", 32'(req_n), 32'd0);

    // Fetch stall with a stray start mid-run
    clear_logs();
    req_ready = 1'b0;
    pulse_start(32'd8, 32'd8, 32'd8);
    for (int i = 0; i < 20; i++) begin
      if (req_valid) break;
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      start = (i == 4);
      if (i == 4) begin
        m_size = 32'd5;  k_size = 32'd6;  n_size = 32'd3;
      end
      check_val("stall_addr", req_addr, 32'h0000_1000);
      check_val("stall_ctl", {6'd0, req_valid, req_is_wgt, req_stride[7:0],
                              req_rows[7:0], req_cols[7:0]}, 32'h0308_0404);
    end
    start = 1'b0;
    check_val("stall_status", status, 32'h0000_0001);
    req_ready = 1'b1;
    wait_done("stall");
    check_val("stall_final", status, 32'h0004_0002);
    check_val("stall_req_cnt", 32'(req_n), 32'd16);

    // Reset while waiting for the array
    clear_logs();
    done_en = 1'b0;
    pulse_start(32'd8, 32'd8, 32'd8);
    for (int i = 0; i < 40; i++) begin
      if (cmp_n != 0) break;
      tick();
    end
    tick();
    check_val("pre_rst_wait", 32'(dut.state_r), 32'(S_WAIT));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("mid_rst_status", status, 32'd0);
    check_val("mid_rst_ctl", {27'd0, req_valid, req_is_wgt, cmp_valid, cmp_first, cmp_last}, 32'd0);
    check_val("mid_rst_addr", req_addr, 32'd0);
    check_val("mid_rst_state", 32'(dut.state_r), 32'(S_IDLE));
    done_en = 1'b1;
    clear_logs();
    pulse_start(32'd8, 32'd8, 32'd8);
    wait_done("post_rst");
    check_val("post_rst_status", status, 32'h0004_0002);
    check_val("post_rst_cmp_cnt", 32'(cmp_n), 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
